// File: rtl/readout_rx_meas_window_scheduler.sv
// -----------------------------------------------------------------------------
// readout_rx_meas_window_scheduler
// Time-multiplexes one readout_rx state-decision unit (SDU) across NUM_QUBIT
// qubits. Keeps a per-qubit table of SDU coefficients. For each accepted
// measurement request it loads that qubit's coefficients into the SDU, which is
// skipped when they are already resident. It then frames the integration window
// with start/finish strobes. Finally it returns the SDU result tagged with the
// qubit id, or a timeout response if no result arrives.
//
// Ports
//   i_clk, i_rst_n                 clock (rising edge), async active-low reset
//   i_tbl_wr_en/qubit/addr/data    host write into the coefficient table
//   i_req_valid, o_req_ready       request handshake (ready only while idle)
//   i_req_qubit, i_req_window      qubit to measure, number of valid samples
//   i_sample_valid_in              sample strobe shared with the SDU valid_in
//   o_sdu_coeff_wr_en/addr/data    coefficient load port towards the SDU
//   o_sdu_start_count/finish_count window framing towards the SDU
//   i_sdu_valid_meas_result_in     SDU result strobe
//   i_sdu_meas_result_in           SDU state decision bit
//   o_rsp_valid                    one-cycle response pulse
//   o_rsp_qubit/result/timeout     response tag, state bit, timeout flag (held)
// -----------------------------------------------------------------------------
module readout_rx_meas_window_scheduler #(
    parameter int unsigned DATA_WIDTH                = 16,
    parameter int unsigned STATE_DECISION_ADDR_WIDTH = 1,
    parameter int unsigned NUM_QUBIT                 = 4,
    parameter int unsigned QUBIT_ID_WIDTH            = 2,
    parameter int unsigned WINDOW_WIDTH              = 16,
    parameter int unsigned TIMEOUT_CYCLES            = 64
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_tbl_wr_en,
    input  logic [QUBIT_ID_WIDTH-1:0]            i_tbl_wr_qubit,
    input  logic [STATE_DECISION_ADDR_WIDTH-1:0] i_tbl_wr_addr,
    input  logic [DATA_WIDTH-1:0]                i_tbl_wr_data,
    input  logic                                 i_req_valid,
    output logic                                 o_req_ready,
    input  logic [QUBIT_ID_WIDTH-1:0]            i_req_qubit,
    input  logic [WINDOW_WIDTH-1:0]              i_req_window,
    input  logic                                 i_sample_valid_in,
    output logic                                 o_sdu_coeff_wr_en,
    output logic [STATE_DECISION_ADDR_WIDTH-1:0] o_sdu_coeff_wr_addr,
    output logic [DATA_WIDTH-1:0]                o_sdu_coeff_wr_data,
    output logic                                 o_sdu_start_count,
    output logic                                 o_sdu_finish_count,
    input  logic                                 i_sdu_valid_meas_result_in,
    input  logic                                 i_sdu_meas_result_in,
    output logic                                 o_rsp_valid,
    output logic [QUBIT_ID_WIDTH-1:0]            o_rsp_qubit,
    output logic                                 o_rsp_result,
    output logic                                 o_rsp_timeout
);

    localparam int unsigned AW        = STATE_DECISION_ADDR_WIDTH;
    localparam int unsigned NUM_WORDS = 1 << AW;
    localparam int unsigned TMR_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [AW-1:0]    LAST_ADDR = AW'(NUM_WORDS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                      r_state;
    state_t                      w_next;

    logic [DATA_WIDTH-1:0]       r_table [NUM_QUBIT][NUM_WORDS];
    logic [QUBIT_ID_WIDTH-1:0]   r_qubit;
    logic [WINDOW_WIDTH-1:0]     r_win;
    logic [AW-1:0]               r_addr;
    logic [WINDOW_WIDTH-1:0]     r_cnt;
    logic [TMR_W-1:0]            r_tmr;
    logic [QUBIT_ID_WIDTH-1:0]   r_loaded_qubit;
    logic                        r_loaded_valid;
    logic                        r_load_dirty;
    logic [QUBIT_ID_WIDTH-1:0]   r_rsp_qubit;
    logic                        r_rsp_result;
    logic                        r_rsp_timeout;

    logic                        w_tbl_wr_ok;
    logic                        w_tbl_wr_loaded;
    logic                        w_tbl_wr_cur;
    logic                        w_skip;
    logic [DATA_WIDTH-1:0]       w_rd_data;
    logic                        w_accept;
    logic                        w_load_last;
    logic                        w_result_hit;
    logic                        w_timeout_hit;

    // Table write qualification and hits against the resident / in-flight qubit
    assign w_tbl_wr_ok     = i_tbl_wr_en && (32'(i_tbl_wr_qubit) < NUM_QUBIT);
    assign w_tbl_wr_loaded = w_tbl_wr_ok && (i_tbl_wr_qubit == r_loaded_qubit);
    assign w_tbl_wr_cur    = w_tbl_wr_ok && (i_tbl_wr_qubit == r_qubit);

    // Resident coefficients are reusable only if not being overwritten right now
    assign w_skip = r_loaded_valid && (i_req_qubit == r_loaded_qubit) && !w_tbl_wr_loaded;

    // Combinational read: a same-cycle write is only visible on the next cycle
    assign w_rd_data = r_table[r_qubit][r_addr];

    assign o_rsp_qubit   = r_rsp_qubit;
    assign o_rsp_result  = r_rsp_result;
    assign o_rsp_timeout = r_rsp_timeout;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and SDU-facing strobes
    always_comb begin
        w_next              = r_state;
        o_req_ready         = 1'b0;
        o_sdu_coeff_wr_en   = 1'b0;
        o_sdu_coeff_wr_addr = '0;
        o_sdu_coeff_wr_data = '0;
        o_sdu_start_count   = 1'b0;
        o_sdu_finish_count  = 1'b0;
        o_rsp_valid         = 1'b0;
        w_accept            = 1'b0;
        w_load_last         = 1'b0;
        w_result_hit        = 1'b0;
        w_timeout_hit       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_accept = 1'b1;
                    w_next   = w_skip ? S_COUNT : S_LOAD;
                end
            end
            S_LOAD: begin
                o_sdu_coeff_wr_en   = 1'b1;
                o_sdu_coeff_wr_addr = r_addr;
                o_sdu_coeff_wr_data = w_rd_data;
                if (r_addr == LAST_ADDR) begin
                    w_load_last = 1'b1;
                    w_next      = S_COUNT;
                end
            end
            S_COUNT: begin
                if (i_sample_valid_in) begin
                    o_sdu_start_count = (r_cnt == '0);
                    if (r_cnt == (r_win - WINDOW_WIDTH'(1))) begin
                        o_sdu_finish_count = 1'b1;
                        w_next             = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A result in the last timer cycle beats the timeout
                if (i_sdu_valid_meas_result_in) begin
                    w_result_hit = 1'b1;
                    w_next       = S_RESP;
                end else if (r_tmr == TMR_LAST) begin
                    w_timeout_hit = 1'b1;
                    w_next        = S_RESP;
                end
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                w_next      = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Coefficient table
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int q = 0; q < int'(NUM_QUBIT); q++) begin
                for (int a = 0; a < int'(NUM_WORDS); a++) begin
                    r_table[q][a] <= '0;
                end
            end
        end else if (w_tbl_wr_ok) begin
            r_table[i_tbl_wr_qubit][i_tbl_wr_addr] <= i_tbl_wr_data;
        end
    end

    // Request latch, load address, sample counter and wait timer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_qubit <= '0;
            r_win   <= WINDOW_WIDTH'(1);
            r_addr  <= '0;
            r_cnt   <= '0;
            r_tmr   <= '0;
        end else begin
            if (w_accept) begin
                r_qubit <= i_req_qubit;
                r_win   <= (i_req_window == '0) ? WINDOW_WIDTH'(1) : i_req_window;
            end
            r_addr <= (r_state == S_LOAD) ? r_addr + AW'(1) : '0;
            if (r_state != S_COUNT) begin
                r_cnt <= '0;
            end else if (i_sample_valid_in) begin
                r_cnt <= r_cnt + WINDOW_WIDTH'(1);
            end
            r_tmr <= (r_state == S_WAIT) ? r_tmr + TMR_W'(1) : '0;
        end
    end

    // Tracks which qubit's coefficients are resident in the SDU
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_loaded_qubit <= '0;
            r_loaded_valid <= 1'b0;
            r_load_dirty   <= 1'b0;
        end else begin
            // A write to the qubit being loaded may leave a stale word in the SDU
            if (w_accept) begin
                r_load_dirty <= 1'b0;
            end else if ((r_state == S_LOAD) && w_tbl_wr_cur) begin
                r_load_dirty <= 1'b1;
            end

            if (w_load_last) begin
                r_loaded_qubit <= r_qubit;
                r_loaded_valid <= !(r_load_dirty || w_tbl_wr_cur);
            end else if ((w_accept && !w_skip) || w_timeout_hit || w_tbl_wr_loaded) begin
                r_loaded_valid <= 1'b0;
            end
        end
    end

    // Response registers, held between responses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_qubit   <= '0;
            r_rsp_result  <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else if (w_result_hit) begin
            r_rsp_qubit   <= r_qubit;
            r_rsp_result  <= i_sdu_meas_result_in;
            r_rsp_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_rsp_qubit   <= r_qubit;
            r_rsp_result  <= 1'b0;
            r_rsp_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_readout_rx_meas_window_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for readout_rx_meas_window_scheduler. A transaction-level model
// (coefficient table mirror, resident-qubit flag, per-request phase timeline)
// predicts every cycle's SDU strobes and each response.
// -----------------------------------------------------------------------------
module tb_readout_rx_meas_window_scheduler;

    localparam int NUM_WORDS = 2;
    localparam int TO        = 64;

    logic        clk;
    logic        rst_n;
    logic        tbl_wr_en;
    logic [1:0]  tbl_wr_qubit;
    logic [0:0]  tbl_wr_addr;
    logic [15:0] tbl_wr_data;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_qubit;
    logic [15:0] req_window;
    logic        sample_valid;
    logic        coeff_wr_en;
    logic [0:0]  coeff_wr_addr;
    logic [15:0] coeff_wr_data;
    logic        start_count;
    logic        finish_count;
    logic        res_valid;
    logic        res_bit;
    logic        rsp_valid;
    logic [1:0]  rsp_qubit;
    logic        rsp_result;
    logic        rsp_timeout;

    logic [15:0] m_table [4][NUM_WORDS];
    bit          m_lv;
    logic [1:0]  m_lq;
    int          n_tests;
    int          n_fail;

    readout_rx_meas_window_scheduler dut (
        .i_clk                      (clk),
        .i_rst_n                    (rst_n),
        .i_tbl_wr_en                (tbl_wr_en),
        .i_tbl_wr_qubit             (tbl_wr_qubit),
        .i_tbl_wr_addr              (tbl_wr_addr),
        .i_tbl_wr_data              (tbl_wr_data),
        .i_req_valid                (req_valid),
        .o_req_ready                (req_ready),
        .i_req_qubit                (req_qubit),
        .i_req_window               (req_window),
        .i_sample_valid_in          (sample_valid),
        .o_sdu_coeff_wr_en          (coeff_wr_en),
        .o_sdu_coeff_wr_addr        (coeff_wr_addr),
        .o_sdu_coeff_wr_data        (coeff_wr_data),
        .o_sdu_start_count          (start_count),
        .o_sdu_finish_count         (finish_count),
        .i_sdu_valid_meas_result_in (res_valid),
        .i_sdu_meas_result_in       (res_bit),
        .o_rsp_valid                (rsp_valid),
        .o_rsp_qubit                (rsp_qubit),
        .o_rsp_result               (rsp_result),
        .o_rsp_timeout              (rsp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        tbl_wr_en    = 1'b0;
        tbl_wr_qubit = '0;
        tbl_wr_addr  = '0;
        tbl_wr_data  = '0;
        req_valid    = 1'b0;
        req_qubit    = '0;
        req_window   = '0;
        sample_valid = 1'b0;
        res_valid    = 1'b0;
        res_bit      = 1'b0;
    endtask

    task automatic model_reset();
        for (int q = 0; q < 4; q++)
            for (int a = 0; a < NUM_WORDS; a++)
                m_table[q][a] = 16'h0000;
        m_lv = 1'b0;
        m_lq = 2'd0;
    endtask

    // Host table write in an idle cycle; model follows after the edge
    task automatic tbl_write(input logic [1:0] q, input int a, input logic [15:0] d);
        tbl_wr_en    = 1'b1;
        tbl_wr_qubit = q;
        tbl_wr_addr  = 1'(a);
        tbl_wr_data  = d;
        @(posedge clk); #1;
        tbl_wr_en = 1'b0;
        m_table[q][a] = d;
        if (q == m_lq) m_lv = 1'b0;
    endtask

    // One measurement transaction, checked every cycle against the model.
    // res_delay: WAIT-cycle index of the SDU result (>= TO means never).
    // wr_mode: 0 none, 1 random table writes after load, 2 one write to q in COUNT.
    task automatic run_meas(input logic [1:0] q, input logic [15:0] win_in, input int res_delay,
                            input logic res_val, input int p_sample, input int wr_mode);
        int         win, phase, c, seen, widx, wa;
        bit         done, sv, wrote, wr, res_drv;
        logic [1:0] wq;
        logic [15:0] wd;
        logic [4:0] exp_ctrl, got_ctrl;
        logic [16:0] exp_coeff;
        logic       exp_res, exp_to;
        win   = (win_in == 16'd0) ? 1 : int'(win_in);
        phase = (m_lv && m_lq == q) ? 1 : 0;
        c = 0; seen = 0; widx = 0; done = 1'b0; wrote = 1'b0; exp_res = 1'b0; exp_to = 1'b0;

        req_valid    = 1'b1;
        req_qubit    = q;
        req_window   = win_in;
        sample_valid = 1'($urandom_range(1));
        res_valid    = 1'($urandom_range(1));
        res_bit      = 1'($urandom_range(1));
        @(negedge clk);
        got_ctrl = {req_ready, coeff_wr_en, start_count, finish_count, rsp_valid};
        n_tests++;
        if (got_ctrl !== 5'b10000) begin
            n_fail++;
            $display("FAIL accept_ctrl q%0d: got %b want 10000 (ready,wr,start,finish,rsp)", q, got_ctrl);
        end
        @(posedge clk); #1;

        while (!done && c < 3000) begin
            c++;
            sv           = ($urandom_range(99) < p_sample);
            sample_valid = sv;
            res_drv      = (phase == 2) ? (widx == res_delay) : ($urandom_range(4) == 0);
            res_valid    = res_drv;
            res_bit      = (phase == 2 && res_drv) ? res_val : 1'($urandom_range(1));
            req_valid    = (phase != 3) && ($urandom_range(3) == 0);
            req_qubit    = 2'($urandom_range(3));
            req_window   = 16'($urandom_range(5));
            wr = 1'b0;
            if (phase >= 1) begin
                if (wr_mode == 1) wr = ($urandom_range(9) == 0);
                else if (wr_mode == 2 && phase == 1 && !wrote) begin
                    wr    = 1'b1;
                    wrote = 1'b1;
                end
            end
            wq = (wr_mode == 2) ? q : 2'($urandom_range(3));
            wa = int'($urandom_range(1));
            wd = 16'($urandom);
            tbl_wr_en    = wr;
            tbl_wr_qubit = wq;
            tbl_wr_addr  = 1'(wa);
            tbl_wr_data  = wd;

            @(negedge clk);
            exp_ctrl = 5'b00000;
            if (phase == 0) exp_ctrl[3] = 1'b1;
            if (phase == 1 && sv) begin
                exp_ctrl[2] = (seen + 1 == 1);
                exp_ctrl[1] = (seen + 1 == win);
            end
            if (phase == 3) exp_ctrl[0] = 1'b1;
            got_ctrl = {req_ready, coeff_wr_en, start_count, finish_count, rsp_valid};
            n_tests++;
            if (got_ctrl !== exp_ctrl) begin
                n_fail++;
                $display("FAIL cycle_ctrl q%0d cyc%0d: got %b want %b (ready,wr,start,finish,rsp)",
                         q, c, got_ctrl, exp_ctrl);
            end
            if (phase == 0) begin
                exp_coeff = {1'(c - 1), m_table[q][c - 1]};
                n_tests++;
                if ({coeff_wr_addr, coeff_wr_data} !== exp_coeff) begin
                    n_fail++;
                    $display("FAIL coeff_write q%0d cyc%0d: got addr/data %h want %h",
                             q, c, {coeff_wr_addr, coeff_wr_data}, exp_coeff);
                end
            end
            if (phase == 3) begin
                n_tests++;
                if ({rsp_qubit, rsp_result, rsp_timeout} !== {q, exp_res, exp_to}) begin
                    n_fail++;
                    $display("FAIL rsp_fields q%0d: got qubit/result/timeout %b want %b",
                             q, {rsp_qubit, rsp_result, rsp_timeout}, {q, exp_res, exp_to});
                end
            end

            if (wr) begin
                m_table[wq][wa] = wd;
                if (wq == m_lq) m_lv = 1'b0;
            end
            case (phase)
                0: if (c == NUM_WORDS) begin m_lv = 1'b1; m_lq = q; phase = 1; end
                1: if (sv) begin seen++; if (seen == win) phase = 2; end
                2: begin
                    if (res_drv) begin
                        exp_res = res_val; exp_to = 1'b0; phase = 3;
                    end else if (widx == TO - 1) begin
                        exp_res = 1'b0; exp_to = 1'b1; m_lv = 1'b0; phase = 3;
                    end else begin
                        widx++;
                    end
                end
                default: done = 1'b1;
            endcase
            @(posedge clk); #1;
        end

        idle_inputs();
        sample_valid = 1'($urandom_range(1));
        res_valid    = 1'($urandom_range(1));
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL meas_response q%0d: no response within %0d cycles", q, c);
        end else begin
            @(negedge clk);
            got_ctrl = {req_ready, coeff_wr_en, start_count, finish_count, rsp_valid};
            if (got_ctrl !== 5'b10000 || {rsp_qubit, rsp_result, rsp_timeout} !== {q, exp_res, exp_to}) begin
                n_fail++;
                $display("FAIL back_to_idle q%0d: got ctrl %b rsp %b want ctrl 10000 rsp %b",
                         q, got_ctrl, {rsp_qubit, rsp_result, rsp_timeout}, {q, exp_res, exp_to});
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        logic [4:0] got_ctrl;
        idle_inputs();
        rst_n        = 1'b0;
        req_valid    = 1'b1;
        sample_valid = 1'b1;
        res_valid    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got_ctrl = {req_ready, coeff_wr_en, start_count, finish_count, rsp_valid};
        n_tests++;
        if (got_ctrl !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 10000", got_ctrl);
        end
        n_tests++;
        if ({coeff_wr_addr, coeff_wr_data, rsp_qubit, rsp_result, rsp_timeout} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0",
                     {coeff_wr_addr, coeff_wr_data, rsp_qubit, rsp_result, rsp_timeout});
        end
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_load_and_measure();
        tbl_write(2'd2, 0, 16'h0003);
        tbl_write(2'd2, 1, 16'hFFF0);
        run_meas(2'd2, 16'd4, 3, 1'b1, 70, 0);
    endtask

    task automatic test_skip_load();
        run_meas(2'd2, 16'd4, 2, 1'b0, 60, 0);
    endtask

    task automatic test_window_one();
        tbl_write(2'd1, 0, 16'h1111);
        tbl_write(2'd1, 1, 16'h2222);
        run_meas(2'd1, 16'd1, 0, 1'b1, 50, 0);
        run_meas(2'd1, 16'd0, 5, 1'b0, 50, 0);
    endtask

    task automatic test_timeout();
        tbl_write(2'd0, 0, 16'hA5A5);
        tbl_write(2'd0, 1, 16'h5A5A);
        run_meas(2'd0, 16'd2, 1000, 1'b0, 80, 0);
        run_meas(2'd0, 16'd2, TO - 1, 1'b1, 80, 0);
        run_meas(2'd0, 16'd3, 4, 1'b1, 80, 0);
    endtask

    task automatic test_write_during_count();
        run_meas(2'd2, 16'd3, 2, 1'b1, 70, 2);
        run_meas(2'd2, 16'd3, 2, 1'b0, 70, 0);
    endtask

    task automatic test_reset_mid_count();
        logic [4:0] got_ctrl;
        tbl_write(2'd3, 0, 16'h1234);
        tbl_write(2'd3, 1, 16'h5678);
        req_valid    = 1'b1;
        req_qubit    = 2'd3;
        req_window   = 16'd20;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (NUM_WORDS + 2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got ready %b want 0", req_ready);
        end
        #1;
        rst_n = 1'b0;
        #1;
        got_ctrl = {req_ready, coeff_wr_en, start_count, finish_count, rsp_valid};
        n_tests++;
        if (got_ctrl !== 5'b10000 || {rsp_qubit, rsp_result, rsp_timeout} !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got ctrl %b rsp %b want ctrl 10000 rsp 0000",
                     got_ctrl, {rsp_qubit, rsp_result, rsp_timeout});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_mid_hold cyc%0d: got rsp_valid %b ready %b want 0 1",
                         i, rsp_valid, req_ready);
            end
        end
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        run_meas(2'd3, 16'd3, 2, 1'b1, 80, 0);
    endtask

    task automatic test_random();
        logic [1:0]  q;
        logic [15:0] w;
        int          d;
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(2) == 0)
                tbl_write(2'($urandom_range(3)), int'($urandom_range(1)), 16'($urandom));
            q = 2'($urandom_range(3));
            w = 16'($urandom_range(8));
            d = ($urandom_range(9) == 0) ? TO + int'($urandom_range(10)) : int'($urandom_range(12));
            run_meas(q, w, d, 1'($urandom_range(1)), 30 + int'($urandom_range(70)),
                     int'($urandom_range(1)));
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        test_reset();
        test_load_and_measure();
        test_skip_load();
        test_window_one();
        test_timeout();
        test_write_during_count();
        test_reset_mid_count();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
